sha256_msg_loader: RTL and testbench

//  Upstream of the RV32I core for SHA-256 runs. Accepts a byte stream and writes one

---
 rtl/sha256_msg_loader.sv | 167 ++++++++++++++++
 tb/tb_sha256_msg_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_loader.sv
// Packs a byte stream into one FIPS 180-4 padded 512-bit block and writes it as 16
// big-endian words to data memory, holding the core in reset until the block is complete.
module sha256_msg_loader #(
   parameter int BASE_ADDR = 100,
   parameter int ADDR_W    = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              done,
   output logic              err,
   output logic              core_reset_n
);

   typedef enum logic [2:0] {
      S_ACCEPT, S_FLUSH, S_PAD, S_ZERO, S_LEN, S_DONE, S_ERR
   } state_t;

   state_t            r_state, w_state_next;
   logic [5:0]        r_len, w_len_next;
   logic [31:0]       r_word, w_word_next;
   logic [3:0]        r_widx, w_widx_next;
   logic              r_in_ready;
   logic              r_mem_we, w_we_next;
   logic [ADDR_W-1:0] r_mem_addr, w_addr_next;
   logic [31:0]       r_mem_wdata, w_wdata_next;
   logic              r_done, w_done_next;
   logic              r_err, w_err_next;
   logic              r_core_reset_n, w_crn_next;

   logic              w_accept;
   logic [1:0]        w_lane;
   logic [31:0]       w_word_acc;
   logic [31:0]       w_pad_bit;
   logic [ADDR_W-1:0] w_cur_addr;

   assign w_accept   = in_valid & r_in_ready & (r_state == S_ACCEPT);
   assign w_lane     = r_len[1:0];
   assign w_cur_addr = ADDR_W'(BASE_ADDR) + {{(ADDR_W-4){1'b0}}, r_widx};

   // Unfilled lanes of r_word are always zero, so OR-ing in the pad marker is enough.
   always_comb begin
      w_word_acc = r_word;
      w_pad_bit  = 32'h0;
      case (w_lane)
         2'd0: begin w_word_acc[31:24] = in_data; w_pad_bit = 32'h0080_0000; end
         2'd1: begin w_word_acc[23:16] = in_data; w_pad_bit = 32'h0000_8000; end
         2'd2: begin w_word_acc[15:8]  = in_data; w_pad_bit = 32'h0000_0080; end
         default: w_word_acc[7:0] = in_data;
      endcase
   end

   // Output registers carry the action of the state being entered.
   always_comb begin
      w_state_next = r_state;
      w_len_next   = r_len;
      w_word_next  = r_word;
      w_widx_next  = r_widx;
      w_we_next    = 1'b0;
      w_addr_next  = r_mem_addr;
      w_wdata_next = r_mem_wdata;
      w_done_next  = 1'b0;
      w_err_next   = 1'b0;
      w_crn_next   = 1'b0;
      case (r_state)
         S_ACCEPT: begin
            if (w_accept) begin
               w_len_next  = 6'(r_len + 6'd1);
               w_word_next = w_word_acc;
               if (in_last) begin
                  w_we_next    = 1'b1;
                  w_addr_next  = w_cur_addr;
                  w_widx_next  = 4'(r_widx + 4'd1);
                  w_word_next  = 32'h0;
                  if (w_lane == 2'd3) begin
                     w_state_next = S_FLUSH;
                     w_wdata_next = w_word_acc;
                  end else begin
                     w_state_next = S_PAD;
                     w_wdata_next = w_word_acc | w_pad_bit;
                  end
               end else if (r_len == 6'd54) begin
                  w_state_next = S_ERR;
                  w_err_next   = 1'b1;
               end else if (w_lane == 2'd3) begin
                  w_we_next    = 1'b1;
                  w_addr_next  = w_cur_addr;
                  w_wdata_next = w_word_acc;
                  w_widx_next  = 4'(r_widx + 4'd1);
                  w_word_next  = 32'h0;
               end
            end
         end
         S_FLUSH: begin
            w_state_next = S_PAD;
            w_we_next    = 1'b1;
            w_addr_next  = w_cur_addr;
            w_wdata_next = 32'h8000_0000;
            w_widx_next  = 4'(r_widx + 4'd1);
         end
         S_PAD, S_ZERO: begin
            w_we_next   = 1'b1;
            w_addr_next = w_cur_addr;
            w_widx_next = 4'(r_widx + 4'd1);
            if (r_widx == 4'd15) begin
               w_state_next = S_LEN;
               w_wdata_next = {23'b0, r_len, 3'b0};
            end else begin
               w_state_next = S_ZERO;
               w_wdata_next = 32'h0;
            end
         end
         S_LEN, S_DONE: begin
            w_state_next = S_DONE;
            w_done_next  = 1'b1;
            w_crn_next   = 1'b1;
         end
         default: begin
            w_state_next = S_ERR;
            w_err_next   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= S_ACCEPT;
         r_len          <= 6'd0;
         r_word         <= 32'h0;
         r_widx         <= 4'd0;
         r_in_ready     <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= 32'h0;
         r_done         <= 1'b0;
         r_err          <= 1'b0;
         r_core_reset_n <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_len          <= w_len_next;
         r_word         <= w_word_next;
         r_widx         <= w_widx_next;
         r_in_ready     <= (w_state_next == S_ACCEPT);
         r_mem_we       <= w_we_next;
         r_mem_addr     <= w_addr_next;
         r_mem_wdata    <= w_wdata_next;
         r_done         <= w_done_next;
         r_err          <= w_err_next;
         r_core_reset_n <= w_crn_next;
      end
   end

   assign in_ready     = r_in_ready;
   assign mem_we       = r_mem_we;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign done         = r_done;
   assign err          = r_err;
   assign core_reset_n = r_core_reset_n;

endmodule

// File: tb/tb_sha256_msg_loader.sv
// Bench for sha256_msg_loader: fixed vectors, a mid-message reset, and random
// messages checked against a padding model built from byte arrays.
module tb_sha256_msg_loader;
   localparam int BASE = 100;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      string       name;
      string       msg;
      bit          last;
      int          gap;
      int          ia;
      logic [31:0] da;
      int          ib;
      logic [31:0] db;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        done;
   logic        err;
   logic        core_reset_n;

   int checks = 0;
   int errors = 0;
   int          wr_addr[$];
   logic [31:0] wr_data[$];
   logic [31:0] exp_w[$];
   bit          seen[1024];
   int          dup_cnt = 0;

   always #5 clk = ~clk;

   sha256_msg_loader #(.BASE_ADDR(BASE), .ADDR_W(10)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .done(done), .err(err), .core_reset_n(core_reset_n)
   );

   always @(negedge clk) begin
      if (reset && mem_we) begin
         if (seen[int'(mem_addr)]) dup_cnt++;
         seen[int'(mem_addr)] = 1'b1;
         wr_addr.push_back(int'(mem_addr));
         wr_data.push_back(mem_wdata);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      dup_cnt = 0;
      foreach (seen[i]) seen[i] = 1'b0;
   endtask

   // Padding model: message, 0x80, zeros, 64-bit big-endian bit length.
   task automatic build_expected(input bq_t m, input bit last);
      logic [7:0]  blk[64];
      logic [63:0] bits;
      int n;
      exp_w.delete();
      foreach (blk[i]) blk[i] = 8'h0;
      n = m.size();
      foreach (m[i]) blk[i] = m[i];
      if (last) begin
         blk[n] = 8'h80;
         bits = 64'(n) * 64'd8;
         for (int i = 0; i < 8; i++) blk[63-i] = bits[8*i +: 8];
         for (int k = 0; k < 16; k++)
            exp_w.push_back({blk[4*k], blk[4*k+1], blk[4*k+2], blk[4*k+3]});
      end else begin
         // the overflowing byte is never written, so only full words before it land
         for (int k = 0; k < (n - 1) / 4; k++)
            exp_w.push_back({blk[4*k], blk[4*k+1], blk[4*k+2], blk[4*k+3]});
      end
   endtask

   task automatic send_msg(input bq_t m, input bit last, input int gap_max, output bit ok);
      bit acc;
      int g;
      ok = 1'b1;
      foreach (m[i]) begin
         g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         repeat (g) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = m[i];
         in_last  = last && (i == m.size() - 1);
         acc = 1'b0;
         for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
         end
         if (!acc) begin
            ok = 1'b0;
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_end(output bit fin);
      fin = 1'b0;
      for (int t = 0; t < 60 && !fin; t++) begin
         @(negedge clk);
         fin = done | err;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (2) @(posedge clk);
      clear_log();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic body(input string name, input bq_t m, input bit last, input int gap,
                       input int ia, input logic [31:0] da, input int ib, input logic [31:0] db);
      bit ok, fin;
      bit exp_err;
      int nw;
      exp_err = !last;
      build_expected(m, last);
      send_msg(m, last, gap, ok);
      check({name, " bytes accepted"}, 32'(ok), 32'd1);
      @(negedge clk);
      check({name, " in_ready low after last byte"}, 32'(in_ready), 32'd0);
      check({name, " err next cycle"}, 32'(err), 32'(exp_err));
      wait_end(fin);
      if (exp_err) begin
         in_valid = 1'b1;
         repeat (6) begin
            in_data = 8'($urandom);
            in_last = 1'($urandom);
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
         in_last  = 1'b0;
         repeat (3) @(negedge clk);
      end
      check({name, " finished"}, 32'(fin), 32'd1);
      check({name, " done"}, 32'(done), 32'(!exp_err));
      check({name, " err"}, 32'(err), 32'(exp_err));
      check({name, " core_reset_n"}, 32'(core_reset_n), 32'(!exp_err));
      check({name, " in_ready idle"}, 32'(in_ready), 32'd0);
      check({name, " write count"}, 32'(wr_data.size()), 32'(exp_w.size()));
      check({name, " duplicate addresses"}, 32'(dup_cnt), 32'd0);
      nw = (wr_data.size() < exp_w.size()) ? wr_data.size() : exp_w.size();
      for (int i = 0; i < nw; i++) begin
         check($sformatf("%s write%0d addr", name, i), 32'(wr_addr[i]), 32'(BASE + i));
         check($sformatf("%s write%0d data", name, i), wr_data[i], exp_w[i]);
      end
      if (ia >= 0)
         check($sformatf("%s word%0d", name, ia), (ia < wr_data.size()) ? wr_data[ia] : 32'hxxxx_xxxx, da);
      if (ib >= 0)
         check($sformatf("%s word%0d", name, ib), (ib < wr_data.size()) ? wr_data[ib] : 32'hxxxx_xxxx, db);
      $display("%s: %0d bytes last=%0b gap<=%0d -> %0d writes, done=%0b err=%0b core_reset_n=%0b",
               name, m.size(), last, gap, wr_data.size(), done, err, core_reset_n);
   endtask

   function automatic bq_t to_bytes(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
      return q;
   endfunction

   vec_t vt[5];

   initial begin
      string a55;
      bq_t   q;
      int    n;

      a55 = "";
      for (int i = 0; i < 55; i++) a55 = {a55, "a"};
      vt[0] = '{"hello",      "hello world", 1'b1, 0,  2, 32'h726c6480, 15, 32'h00000058};
      vt[1] = '{"abcd",       "abcd",        1'b1, 0,  1, 32'h80000000, 15, 32'h00000020};
      vt[2] = '{"a55_last",   a55,           1'b1, 0, 13, 32'h61616180, 15, 32'h000001b8};
      vt[3] = '{"a55_nolast", a55,           1'b0, 0, 12, 32'h61616161, -1, 32'h0};
      vt[4] = '{"hello_gaps", "hello world", 1'b1, 3,  2, 32'h726c6480, 15, 32'h00000058};

      // Reset state and in_ready rising one cycle after release.
      #12;
      check("reset in_ready", 32'(in_ready), 32'd0);
      check("reset mem_we", 32'(mem_we), 32'd0);
      check("reset mem_addr", 32'(mem_addr), 32'd0);
      check("reset mem_wdata", mem_wdata, 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset err", 32'(err), 32'd0);
      check("reset core_reset_n", 32'(core_reset_n), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("in_ready before first edge", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check("in_ready after first edge", 32'(in_ready), 32'd1);

      foreach (vt[v]) begin
         do_reset();
         body(vt[v].name, to_bytes(vt[v].msg), vt[v].last, vt[v].gap,
              vt[v].ia, vt[v].da, vt[v].ib, vt[v].db);
      end

      // Reset pulled mid-message, then a fresh short message.
      do_reset();
      q = to_bytes("qwerty");
      begin
         bit ok6;
         send_msg(q, 1'b0, 0, ok6);
         check("reset_mid first bytes accepted", 32'(ok6), 32'd1);
      end
      #3;
      reset = 1'b0;
      #1;
      check("reset_mid in_ready", 32'(in_ready), 32'd0);
      check("reset_mid mem_we", 32'(mem_we), 32'd0);
      check("reset_mid done", 32'(done), 32'd0);
      check("reset_mid core_reset_n", 32'(core_reset_n), 32'd0);
      repeat (2) @(posedge clk);
      clear_log();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      body("reset_mid_abc", to_bytes("abc"), 1'b1, 0, 0, 32'h61626380, 15, 32'h00000018);

      // Random messages, with an occasional overlong one.
      for (int r = 0; r < 12; r++) begin
         bit lst;
         do_reset();
         q.delete();
         lst = (r % 4 != 3);
         n = lst ? int'($urandom_range(55, 1)) : 55;
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         body($sformatf("rand%0d", r), q, lst, int'($urandom_range(3, 0)), -1, 32'h0, -1, 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
